// File: rtl/store_buffer.sv
// store_buffer: posted-write store queue between MEM and the byte-addressed data memory, with load-overlap stall.
// Define STORE_FWD_EN to forward an exact-address SW store to an overlapping load instead of stalling it.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [1:0]             st_size,
    input  logic [31:0]            st_data,
    input  logic                   ld_req,
    input  logic [ADDR_W-1:0]      ld_addr,
    output logic                   ld_stall,
    output logic                   ld_fwd_valid,
    output logic [31:0]            ld_fwd_data,
    output logic                   mem_write,
    output logic [1:0]             mem_save_method,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [31:0]            mem_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] SIZE_SB = 2'b00;
    localparam logic [1:0] SIZE_SH = 2'b01;
    localparam logic [1:0] SIZE_SW = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [31:0]       data;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] idx;
    logic             push;
    logic             pop;
    logic             ld_hit;

    // Exclusive end of a store's byte range; the two extra bits keep ranges near the top from wrapping.
    function automatic logic [ADDR_W+1:0] store_end(input logic [ADDR_W-1:0] addr, input logic [1:0] size);
        logic [ADDR_W+1:0] lo;
        lo = {2'b00, addr};
        case (size)
            SIZE_SB: return lo + (ADDR_W+2)'(1);
            SIZE_SH: return lo + (ADDR_W+2)'(2);
            SIZE_SW: return lo + (ADDR_W+2)'(4);
            default: return lo;
        endcase
    endfunction

    function automatic logic overlaps(input logic [ADDR_W-1:0] s_addr, input logic [1:0] s_size,
                                      input logic [ADDR_W-1:0] l_addr);
        logic [ADDR_W+1:0] s_lo;
        logic [ADDR_W+1:0] l_lo;
        logic [ADDR_W+1:0] l_hi;
        s_lo = {2'b00, s_addr};
        l_lo = {2'b00, l_addr};
        l_hi = l_lo + (ADDR_W+2)'(4);
        return (s_lo < l_hi) && (l_lo < store_end(s_addr, s_size));
    endfunction

    assign st_ready = (count != FULL_CNT);
    assign push     = st_valid && st_ready;
    assign pop      = (count != '0);
    assign empty    = (count == '0) && !mem_write;

    // NOTE: payload storage has no reset; validity is carried entirely by count, so reset only touches control state.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{addr: st_addr, size: st_size, data: st_data};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            mem_write       <= 1'b0;
            mem_save_method <= '0;
            mem_addr        <= '0;
            mem_data        <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head            <= head + 1'b1;
                mem_write       <= 1'b1;
                mem_save_method <= entries[head].size;
                mem_addr        <= entries[head].addr;
                mem_data        <= entries[head].data;
            end else begin
                mem_write <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef STORE_FWD_EN
    logic        fwd_match;
    logic [31:0] fwd_word;
`endif

    // Scan oldest (in-flight) to youngest so the last hit is the youngest overlapping store.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        ld_hit = 1'b0;
        idx    = head;
`ifdef STORE_FWD_EN
        fwd_match = 1'b0;
        fwd_word  = '0;
`endif
        if (mem_write && overlaps(mem_addr, mem_save_method, ld_addr)) begin
            ld_hit = 1'b1;
`ifdef STORE_FWD_EN
            fwd_match = (mem_save_method == SIZE_SW) && (mem_addr == ld_addr);
            fwd_word  = mem_data;
`endif
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && overlaps(entries[idx].addr, entries[idx].size, ld_addr)) begin
                ld_hit = 1'b1;
`ifdef STORE_FWD_EN
                fwd_match = (entries[idx].size == SIZE_SW) && (entries[idx].addr == ld_addr);
                fwd_word  = entries[idx].data;
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    assign ld_fwd_valid = ld_req && ld_hit && fwd_match;
    assign ld_fwd_data  = ld_fwd_valid ? fwd_word : 32'h0;
    assign ld_stall     = ld_req && ld_hit && !fwd_match;
`else
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = 32'h0;
    assign ld_stall     = ld_req && ld_hit;
`endif

endmodule
